mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access
Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath and address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum wait cycles for dmem_ack (MEM_TIMEOUT_EN only).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  EX stage presents an operation this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts in_valid this cycle; low means the pipeline must stall.
REQ-007 SHALL have port alu_result  input  DATA_WIDTH  ALUResult from EX; byte address for memory operations, passthrough value otherwise.
REQ-008 SHALL have port store_data  input  DATA_WIDTH  rs2 value for stores.
REQ-009 SHALL have port mem_read  input  1  operation is a load.
REQ-010 SHALL have port mem_write  input  1  operation is a store.
REQ-011 SHALL have port funct3  input  3  access size and sign.
REQ-012 SHALL have port rd_in  input  5  destination register.
REQ-013 SHALL have port dmem_req  output  1  memory request; held high until dmem_ack.
REQ-014 SHALL have port dmem_we  output  1  request is a write.
REQ-015 SHALL have port dmem_addr  output  DATA_WIDTH  word address: alu_result with bits [1:0] forced to 0.
REQ-016 SHALL have port dmem_be  output  4  byte enables.
REQ-017 SHALL have port dmem_wdata  output  DATA_WIDTH  lane-replicated store data.
REQ-018 SHALL have port dmem_rdata  input  DATA_WIDTH  read word, valid when dmem_ack is high.
REQ-019 SHALL have port dmem_ack  input  1  request completes this cycle.
REQ-020 SHALL have port out_valid  output  1  one-cycle pulse; out_data, out_rd and out_exc are valid.
REQ-021 SHALL have ports out_data (output, DATA_WIDTH, writeback value), out_rd (output, 5, destination register) and out_exc (output, 2, bit0 misaligned, bit1 timeout).
Function
REQ-022 SHALL implement FSM states IDLE and ACCESS; in_ready SHALL be 1 only in IDLE.
REQ-023 SHALL, in IDLE with in_valid and neither mem_read nor mem_write, assert out_valid on the next cycle with out_data equal to alu_result (latency 1).
REQ-024 SHALL treat mem_read and mem_write both high as a load; the store SHALL be suppressed.
REQ-025 SHALL flag a misaligned access when funct3[1:0] is 01 and addr[0] is 1, or when funct3[1:0] is 10 and addr[1:0] is nonzero: no dmem_req, out_valid next cycle with out_exc equal to 01 and out_data equal to 0, state remains IDLE.
REQ-026 SHALL, for an aligned memory operation, enter ACCESS; dmem_req/we/addr/be/wdata SHALL be registered and stable from the next cycle until the cycle dmem_ack is sampled high.
REQ-027 SHALL generate store byte enables as follows: SB gives 0001 shifted left by addr[1:0]; SH gives 0011 shifted left by addr[1]*2; SW gives 1111. wdata SHALL be the byte or half replicated across all lanes. Loads SHALL use dmem_be equal to 1111.
REQ-028 SHALL, on dmem_ack in ACCESS, capture dmem_rdata, select the lane by addr[1:0], and extend it: LB and LH sign-extend; LBU and LHU zero-extend; LW passes through. out_valid SHALL follow on the next cycle and the FSM SHALL return to IDLE. Stores SHALL produce out_data equal to 0.
REQ-029 SHALL treat funct3 values 011, 110 and 111 as word accesses.
REQ-030 SHALL ignore dmem_ack when the FSM is in IDLE.
Reset
REQ-031 SHALL, on reset (including during ACCESS), go to IDLE and drive in_ready to 1 and dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, out_valid, out_data, out_rd and out_exc to 0; the timeout counter SHALL be cleared to 0.
Configuration
REQ-032 SHALL, with MEM_TIMEOUT_EN defined, count ACCESS cycles; when the count reaches TIMEOUT_CYCLES without dmem_ack, the block SHALL drop dmem_req, pulse out_valid with out_exc equal to 10 and out_data equal to 0, and return to IDLE.
REQ-033 SHALL, without MEM_TIMEOUT_EN, contain no counter, wait for dmem_ack indefinitely, and tie out_exc[1] to 0.
Structure
REQ-034 SHALL take the state enum, funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the out_exc bit positions from shared package mem_pkg.
REQ-035 SHALL place lane select and sign/zero extension in combinational sub-module load_extend.
Verification
REQ-036 SHALL verify passthrough: alu_result 0x0000_1234, no memory operation -> out_valid one cycle later, out_data 0x0000_1234, no dmem_req.
REQ-037 SHALL verify a signed byte load: LB at 0x103, dmem_rdata 0x80FF_0000, dmem_ack after 3 cycles -> dmem_addr 0x100, out_data 0xFFFF_FF80, in_ready low throughout.
REQ-038 SHALL verify a halfword store: SH at 0x202, store_data 0xAAAA_BEEF -> dmem_be 1100, dmem_wdata 0xBEEF_BEEF, dmem_we 1.
REQ-039 SHALL verify a misaligned word access: LW at 0x101 -> no dmem_req, out_exc 01, out_data 0.
REQ-040 SHALL verify timeout: MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES 16, ack never arrives -> out_exc 10 after 16 ACCESS cycles, then in_ready high.
REQ-041 SHALL verify reset during ACCESS: dmem_req drops the next cycle, no out_valid, and a new load is accepted immediately afterwards.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_access load/store stage.
package mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int EXC_MISALIGN = 0;
    localparam int EXC_TIMEOUT  = 1;

    // Byte enables for a store of the given size code (funct3[1:0]).
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            F3_SB[1:0]: return 4'b0001 << off;
            F3_SH[1:0]: return 4'b0011 << {off[1], 1'b0};
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane selection and sign/zero extension of a returned memory word.
module load_extend
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            byte_off,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'(rdata >> {byte_off, 3'b000});
        half_v = 16'(rdata >> {byte_off[1], 4'b0000});
        case (funct3)
            F3_LB:   data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
            F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
            F3_LH:   data = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
            F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Pipeline memory-access stage: passthrough, aligned loads/stores over a req/ack bus.
// Optional MEM_TIMEOUT_EN aborts an access that sees no dmem_ack within TIMEOUT_CYCLES.
module mem_access
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [4:0]            rd_in,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [4:0]            out_rd,
    output logic [1:0]            out_exc
);

    state_t                state_q, state_d;
    logic                  req_q, req_d, we_q, we_d, load_q, load_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic                  out_valid_q, out_valid_d, out_mis_q, out_mis_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [4:0]            out_rd_q, out_rd_d;
    logic [DATA_WIDTH-1:0] lane_wdata, ext_data;
    logic                  misaligned;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_to_q, out_to_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
        .rdata    (dmem_rdata),
        .byte_off (off_q),
        .funct3   (f3_q),
        .data     (ext_data)
    );

    always_comb begin
        case (funct3[1:0])
            F3_SB[1:0]: lane_wdata = {(DATA_WIDTH/8){store_data[7:0]}};
            F3_SH[1:0]: lane_wdata = {(DATA_WIDTH/16){store_data[15:0]}};
            default:    lane_wdata = store_data;
        endcase
        misaligned = ((funct3[1:0] == F3_LH[1:0]) && alu_result[0]) ||
                     ((funct3[1:0] == F3_LW[1:0]) && (alu_result[1:0] != 2'b00));
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        off_d       = off_q;
        load_d      = load_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_mis_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        out_to_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    out_rd_d = rd_in;
                    if (!mem_read && !mem_write) begin
                        out_valid_d = 1'b1;
                        out_data_d  = alu_result;
                    end else if (misaligned) begin
                        out_valid_d = 1'b1;
                        out_data_d  = '0;
                        out_mis_d   = 1'b1;
                    end else begin
                        // A read+write request is a load; the store half is dropped.
                        state_d = ACCESS;
                        req_d   = 1'b1;
                        we_d    = mem_write & ~mem_read;
                        addr_d  = {alu_result[DATA_WIDTH-1:2], 2'b00};
                        be_d    = mem_read ? 4'b1111 : store_be(funct3[1:0], alu_result[1:0]);
                        wdata_d = lane_wdata;
                        f3_d    = funct3;
                        off_d   = alu_result[1:0];
                        load_d  = mem_read;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_d     = IDLE;
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    out_valid_d = 1'b1;
                    out_data_d  = load_q ? ext_data : '0;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_d     = IDLE;
                        req_d       = 1'b0;
                        we_d        = 1'b0;
                        out_valid_d = 1'b1;
                        out_data_d  = '0;
                        out_to_d    = 1'b1;
                        cnt_d       = '0;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            load_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_mis_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
            out_to_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            load_q      <= load_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_mis_q   <= out_mis_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
            out_to_q    <= out_to_d;
`endif
        end
    end

    always_comb begin
        out_exc               = '0;
        out_exc[EXC_MISALIGN] = out_mis_q;
`ifdef MEM_TIMEOUT_EN
        out_exc[EXC_TIMEOUT]  = out_to_q;
`endif
    end

    assign in_ready   = (state_q == IDLE);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_rd     = out_rd_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized ops against a byte-level memory model.
module tb_mem_access;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, mem_read, mem_write;
    logic [DW-1:0] alu_result, store_data, dmem_addr, dmem_wdata, dmem_rdata, out_data;
    logic [2:0]    funct3;
    logic [4:0]    rd_in, out_rd;
    logic          dmem_req, dmem_we, dmem_ack, out_valid;
    logic [3:0]    dmem_be;
    logic [1:0]    out_exc;

    always #5 clk = ~clk;

    mem_access #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .store_data(store_data), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .rd_in(rd_in), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd), .out_exc(out_exc)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] resp_mem [0:15];
    logic [7:0]  ref_bytes [0:63];
    logic        force_en = 1'b0;
    logic [31:0] force_data = '0;

    // Results of the most recent run_op.
    int          r_cyc, r_reqs;
    logic [31:0] r_data, r_addr, r_wdata;
    logic [1:0]  r_exc;
    logic [4:0]  r_rd;
    logic        r_we, r_stable, r_busy_ok, r_ready_issue, r_ready_end, r_done;
    logic [3:0]  r_be;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, act as memory (ack on request cycle lat, 0 = never), and record what happened.
    task automatic run_op(input logic rd_, input logic wr_, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [4:0] rdn, input int lat);
        r_ready_issue = in_ready;
        in_valid = 1'b1; mem_read = rd_; mem_write = wr_; funct3 = f3;
        alu_result = a; store_data = sd; rd_in = rdn;
        step();
        in_valid = 1'b0; mem_read = 1'($urandom); mem_write = 1'($urandom);
        alu_result = $urandom; store_data = $urandom; funct3 = 3'($urandom);
        r_cyc = 0; r_reqs = 0; r_stable = 1'b1; r_busy_ok = 1'b1; r_done = 1'b0; r_ready_end = 1'b0;
        r_data = '0; r_exc = '0; r_rd = '0; r_we = 1'b0; r_addr = '0; r_be = '0; r_wdata = '0;
        for (int c = 1; c <= 200; c++) begin
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            if (out_valid === 1'b1) begin
                r_cyc = c; r_data = out_data; r_exc = out_exc; r_rd = out_rd;
                r_ready_end = in_ready; r_done = 1'b1;
                break;
            end
            if (dmem_req === 1'b1) begin
                if (r_reqs == 0) begin
                    r_we = dmem_we; r_addr = dmem_addr; r_be = dmem_be; r_wdata = dmem_wdata;
                end else if ({dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {r_we, r_addr, r_be, r_wdata}) begin
                    r_stable = 1'b0;
                end
                if (in_ready !== 1'b0) r_busy_ok = 1'b0;
                r_reqs++;
                if (r_reqs == lat) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = force_en ? force_data : resp_mem[dmem_addr[5:2]];
                    if (dmem_we)
                        for (int j = 0; j < 4; j++)
                            if (dmem_be[j]) resp_mem[dmem_addr[5:2]][8*j +: 8] = dmem_wdata[8*j +: 8];
                end
            end
            step();
        end
        dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; mem_read = 1'b1; alu_result = $urandom; dmem_ack = 1'b1;
        step();
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        checks++;
        if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, out_valid, out_data, out_rd, out_exc} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b we=%b be=%h addr=%h wd=%h ov=%b od=%h rd=%h exc=%b exp all zero",
                     dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, out_valid, out_data, out_rd, out_exc);
        end
        reset = 1'b0; in_valid = 1'b0; dmem_ack = 1'b0;
        step();
    endtask

    task automatic test_passthrough();
        run_op(1'b0, 1'b0, 3'b010, 32'h0000_1234, $urandom, 5'd5, 0);
        checks++;
        if (r_ready_issue !== 1'b1) begin errors++; $display("FAIL pass_ready got %b exp 1", r_ready_issue); end
        checks++;
        if (r_cyc !== 1) begin errors++; $display("FAIL pass_latency got %0d exp 1", r_cyc); end
        checks++;
        if (r_data !== 32'h0000_1234) begin errors++; $display("FAIL pass_data got %h exp 00001234", r_data); end
        checks++;
        if (r_reqs !== 0) begin errors++; $display("FAIL pass_noreq got %0d exp 0", r_reqs); end
        checks++;
        if ({r_rd, r_exc} !== {5'd5, 2'b00}) begin errors++; $display("FAIL pass_rd_exc got %h/%b exp 05/00", r_rd, r_exc); end
    endtask

    task automatic test_lb_signed();
        force_en = 1'b1; force_data = 32'h80FF_0000;
        run_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, $urandom, 5'd7, 3);
        force_en = 1'b0;
        checks++;
        if (r_addr !== 32'h0000_0100) begin errors++; $display("FAIL lb_addr got %h exp 00000100", r_addr); end
        checks++;
        if (r_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", r_data); end
        checks++;
        if (r_busy_ok !== 1'b1 || r_reqs !== 3) begin errors++; $display("FAIL lb_busy got ready_low=%b reqs=%0d exp 1/3", r_busy_ok, r_reqs); end
        checks++;
        if (r_cyc !== 4 || r_ready_end !== 1'b1) begin errors++; $display("FAIL lb_latency got %0d/%b exp 4/1", r_cyc, r_ready_end); end
        checks++;
        if ({r_we, r_be, r_stable, r_rd} !== {1'b0, 4'b1111, 1'b1, 5'd7}) begin
            errors++; $display("FAIL lb_bus got we=%b be=%b stable=%b rd=%0d exp 0/1111/1/7", r_we, r_be, r_stable, r_rd);
        end
    endtask

    task automatic test_sh_store();
        run_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd3, 2);
        checks++;
        if (r_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", r_be); end
        checks++;
        if (r_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got %h exp beefbeef", r_wdata); end
        checks++;
        if (r_we !== 1'b1 || r_addr !== 32'h0000_0200) begin errors++; $display("FAIL sh_we_addr got %b/%h exp 1/00000200", r_we, r_addr); end
        checks++;
        if ({r_data, r_exc} !== '0 || r_cyc !== 3 || r_stable !== 1'b1) begin
            errors++; $display("FAIL sh_result got data=%h exc=%b cyc=%0d stable=%b exp 0/00/3/1", r_data, r_exc, r_cyc, r_stable);
        end
    endtask

    task automatic test_misaligned();
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, $urandom, 5'd9, 1);
        checks++;
        if (r_reqs !== 0) begin errors++; $display("FAIL mis_lw_noreq got %0d exp 0", r_reqs); end
        checks++;
        if (r_exc !== 2'b01 || r_data !== '0) begin errors++; $display("FAIL mis_lw_result got %b/%h exp 01/0", r_exc, r_data); end
        checks++;
        if (r_cyc !== 1 || r_ready_end !== 1'b1) begin errors++; $display("FAIL mis_lw_latency got %0d/%b exp 1/1", r_cyc, r_ready_end); end
        run_op(1'b0, 1'b1, 3'b001, 32'h0000_0203, $urandom, 5'd9, 1);
        checks++;
        if (r_reqs !== 0 || r_exc !== 2'b01 || r_cyc !== 1) begin
            errors++; $display("FAIL mis_sh got reqs=%0d exc=%b cyc=%0d exp 0/01/1", r_reqs, r_exc, r_cyc);
        end
    endtask

    task automatic test_ack_idle();
        in_valid = 1'b0; dmem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({out_valid, dmem_req, in_ready} !== 3'b001) begin
                errors++; $display("FAIL idle_ack got ov=%b req=%b ready=%b exp 0/0/1", out_valid, dmem_req, in_ready);
            end
        end
        dmem_ack = 1'b0;
    endtask

    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0020, $urandom, 5'd11, 0);
        checks++;
        if (r_done !== 1'b1 || r_reqs !== TO || r_cyc !== TO + 1) begin
            errors++; $display("FAIL timeout_timing got done=%b reqs=%0d cyc=%0d exp 1/%0d/%0d", r_done, r_reqs, r_cyc, TO, TO + 1);
        end
        checks++;
        if (r_exc !== 2'b10 || r_data !== '0 || r_ready_end !== 1'b1) begin
            errors++; $display("FAIL timeout_result got exc=%b data=%h ready=%b exp 10/0/1", r_exc, r_data, r_ready_end);
        end
`else
        force_en = 1'b1; force_data = 32'hCAFE_F00D;
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0020, $urandom, 5'd11, 40);
        force_en = 1'b0;
        checks++;
        if (r_done !== 1'b1 || r_reqs !== 40 || r_cyc !== 41) begin
            errors++; $display("FAIL long_wait_timing got done=%b reqs=%0d cyc=%0d exp 1/40/41", r_done, r_reqs, r_cyc);
        end
        checks++;
        if (r_exc !== 2'b00 || r_data !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL long_wait_result got exc=%b data=%h exp 00/cafef00d", r_exc, r_data);
        end
`endif
    endtask

    task automatic test_reset_access();
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'b010;
        alu_result = 32'h0000_0010; store_data = $urandom; rd_in = 5'd13;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (dmem_req !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_acc_busy got req=%b ready=%b exp 1/0", dmem_req, in_ready); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, out_valid, out_data, out_rd, out_exc} !== '0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_acc_clear got req=%b ov=%b ready=%b addr=%h exp 0/0/1/0", dmem_req, out_valid, in_ready, dmem_addr);
        end
        force_en = 1'b1; force_data = 32'h1234_5678;
        run_op(1'b1, 1'b0, 3'b101, 32'h0000_0022, $urandom, 5'd14, 2);
        force_en = 1'b0;
        checks++;
        if (r_ready_issue !== 1'b1 || r_cyc !== 3 || r_data !== 32'h0000_1234) begin
            errors++; $display("FAIL rst_acc_next got ready=%b cyc=%0d data=%h exp 1/3/00001234", r_ready_issue, r_cyc, r_data);
        end
    endtask

    task automatic test_random();
        logic        rd_, wr_, mis;
        logic [2:0]  f3;
        logic [31:0] a, sd, exp_data, exp_wdata;
        logic [4:0]  rdn;
        logic [3:0]  exp_be;
        logic [1:0]  exp_exc;
        int          lat, size, off, start, kind, exp_cyc, exp_reqs;
        longint      v;
        for (int w = 0; w < 16; w++) begin
            resp_mem[w] = $urandom;
            for (int b = 0; b < 4; b++) ref_bytes[4*w + b] = resp_mem[w][8*b +: 8];
        end
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 3);
            rd_ = (kind == 1) || (kind == 3);
            wr_ = (kind >= 2);
            f3 = 3'($urandom_range(0, 7));
            sd = $urandom; rdn = 5'($urandom); lat = $urandom_range(1, 4);
            a = (kind == 0) ? $urandom : 32'($urandom_range(0, 63));
            size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            mis = (kind != 0) && ((size == 2 && a % 2 != 0) || (f3[1:0] == 2'd2 && a % 4 != 0));
            off = int'(a % 4) - int'(a % 4) % size;
            start = int'(a - a % 4) + off;
            exp_be = '0; exp_wdata = '0;
            if (kind == 0) begin
                exp_data = a; exp_exc = 2'b00; exp_cyc = 1; exp_reqs = 0;
            end else if (mis) begin
                exp_data = '0; exp_exc = 2'b01; exp_cyc = 1; exp_reqs = 0;
            end else begin
                exp_exc = 2'b00; exp_reqs = lat; exp_cyc = lat + 1;
                for (int i = 0; i < size; i++) exp_be[off + i] = 1'b1;
                for (int j = 0; j < 4; j++) exp_wdata[8*j +: 8] = sd[8*(j % size) +: 8];
                if (rd_) begin
                    v = 0;
                    for (int i = 0; i < size; i++) v = v + (longint'(ref_bytes[start + i]) << (8*i));
                    if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size - 1))) v = v - (longint'(1) << (8*size));
                    exp_data = v[31:0];
                    exp_be = 4'b1111;
                end else begin
                    exp_data = '0;
                    for (int i = 0; i < size; i++) ref_bytes[start + i] = sd[8*i +: 8];
                end
            end
            run_op(rd_, wr_, f3, a, sd, rdn, lat);
            checks++;
            if (r_done !== 1'b1 || r_cyc !== exp_cyc || r_reqs !== exp_reqs) begin
                errors++; $display("FAIL rnd%0d_timing got done=%b cyc=%0d reqs=%0d exp 1/%0d/%0d", n, r_done, r_cyc, r_reqs, exp_cyc, exp_reqs);
            end
            checks++;
            if (r_data !== exp_data || r_exc !== exp_exc || r_rd !== rdn) begin
                errors++; $display("FAIL rnd%0d_result f3=%b a=%h got data=%h exc=%b rd=%0d exp %h/%b/%0d",
                                   n, f3, a, r_data, r_exc, r_rd, exp_data, exp_exc, rdn);
            end
            if (kind != 0 && !mis) begin
                checks++;
                if (r_addr !== {a[31:2], 2'b00} || r_we !== (wr_ && !rd_) || r_be !== exp_be || r_stable !== 1'b1 || r_busy_ok !== 1'b1) begin
                    errors++; $display("FAIL rnd%0d_bus got addr=%h we=%b be=%b stable=%b busy=%b exp %h/%b/%b/1/1",
                                       n, r_addr, r_we, r_be, r_stable, r_busy_ok, {a[31:2], 2'b00}, wr_ && !rd_, exp_be);
                end
                if (!rd_) begin
                    checks++;
                    if (r_wdata !== exp_wdata) begin errors++; $display("FAIL rnd%0d_wdata got %h exp %h", n, r_wdata, exp_wdata); end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
        alu_result = '0; store_data = '0; rd_in = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        test_reset();
        test_passthrough();
        test_lb_signed();
        test_sh_store();
        test_misaligned();
        test_ack_idle();
        test_timeout();
        test_reset_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
